uncache_unit: RTL and testbench

//  Serialises uncached (MMIO, Paddr[31:16]==16'h1faf) loads/stores issued from MEM1 into single-beat

---
 rtl/uncache_unit.sv | 134 +++++++++++++
 tb/tb_uncache_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uncache_unit.sv
// Single-outstanding uncached (MMIO) access sequencer between MEM1 and the AXI bridge uncache port.
// Each access is issued as one beat and completes in a one-cycle DONE state. Stores complete only on the write response.
module uncache_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              MEM1_uncache_valid,
    input  logic              MEM1_DMWr,
    input  logic [1:0]        MEM1_size,
    input  logic [ADDR_W-1:0] MEM1_Paddr,
    input  logic [3:0]        MEM1_dCache_wstrb,
    input  logic [DATA_W-1:0] MEM1_wdata,
    output logic              MEM_uncache_rd_req,
    output logic [2:0]        MEM_uncache_rd_type,
    output logic [ADDR_W-1:0] MEM_uncache_rd_addr,
    input  logic              rd_rdy,
    input  logic              ret_valid,
    input  logic              ret_last,
    input  logic [DATA_W-1:0] ret_data,
    output logic              MEM_uncache_wr_req,
    output logic [2:0]        MEM_uncache_wr_type,
    output logic [ADDR_W-1:0] MEM_uncache_wr_addr,
    output logic [3:0]        MEM_uncache_wr_wstrb,
    output logic [DATA_W-1:0] MEM_uncache_wr_data,
    input  logic              wr_rdy,
    input  logic              wr_ok,
    output logic [DATA_W-1:0] uncache_Out,
    output logic              MEM_unCache_data_ok,
    output logic              uncache_last_stall
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        DONE    = 3'd5
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        type_q;
    logic [3:0]        wstrb_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] out_q;
    logic              rd_req_q;
    logic              wr_req_q;
    logic              last_stall_q;

    function automatic logic [2:0] size_to_type(input logic [1:0] size);
        case (size)
            2'b00:   size_to_type = 3'b000;
            2'b01:   size_to_type = 3'b001;
            default: size_to_type = 3'b010;
        endcase
    endfunction

    // Request and stall flags are registered together with the state so they
    // line up exactly with RD_REQ / WR_REQ / DONE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            type_q       <= '0;
            wstrb_q      <= '0;
            wdata_q      <= '0;
            out_q        <= '0;
            rd_req_q     <= 1'b0;
            wr_req_q     <= 1'b0;
            last_stall_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    last_stall_q <= 1'b0;
                    if (MEM1_uncache_valid) begin
                        addr_q  <= MEM1_Paddr;
                        type_q  <= size_to_type(MEM1_size);
                        wstrb_q <= MEM1_dCache_wstrb;
                        wdata_q <= MEM1_wdata;
                        if (MEM1_DMWr) begin
                            wr_req_q <= 1'b1;
                            state_q  <= WR_REQ;
                        end else begin
                            rd_req_q <= 1'b1;
                            state_q  <= RD_REQ;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RD_REQ: if (rd_rdy) begin
                    rd_req_q <= 1'b0;
                    state_q  <= RD_WAIT;
                end
                // Only the final beat completes a load; lone ret_valid is dropped.
                RD_WAIT: if (ret_valid && ret_last) begin
                    out_q        <= ret_data;
                    last_stall_q <= 1'b1;
                    state_q      <= DONE;
                end
                WR_REQ: if (wr_rdy) begin
                    wr_req_q <= 1'b0;
                    state_q  <= WR_WAIT;
                end
                WR_WAIT: if (wr_ok) begin
                    last_stall_q <= 1'b1;
                    state_q      <= DONE;
                end
                default: begin
                    rd_req_q     <= 1'b0;
                    wr_req_q     <= 1'b0;
                    last_stall_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign MEM_uncache_rd_req   = rd_req_q;
    assign MEM_uncache_rd_type  = type_q;
    assign MEM_uncache_rd_addr  = addr_q;
    assign MEM_uncache_wr_req   = wr_req_q;
    assign MEM_uncache_wr_type  = type_q;
    assign MEM_uncache_wr_addr  = addr_q;
    assign MEM_uncache_wr_wstrb = wstrb_q;
    assign MEM_uncache_wr_data  = wdata_q;
    assign uncache_Out          = out_q;
    assign MEM_unCache_data_ok  = (state_q == IDLE) || (state_q == DONE);
    assign uncache_last_stall   = last_stall_q;

endmodule

// File: tb/tb_uncache_unit.sv
// Directed bench for uncache_unit: expected requests and completion words are queued at issue
// and checked by a negedge monitor when the DUT emits them.
module tb_uncache_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid, dmwr;
    logic [1:0]  size;
    logic [31:0] paddr, wdata;
    logic [3:0]  wstrb;
    logic        rd_req, wr_req;
    logic [2:0]  rd_type, wr_type;
    logic [31:0] rd_addr, wr_addr, wr_data;
    logic [3:0]  wr_wstrb;
    logic        rd_rdy, ret_valid, ret_last, wr_rdy, wr_ok;
    logic [31:0] ret_data, out;
    logic        data_ok, last_stall;

    always #5 clk = ~clk;

    uncache_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .MEM1_uncache_valid(valid), .MEM1_DMWr(dmwr), .MEM1_size(size),
        .MEM1_Paddr(paddr), .MEM1_dCache_wstrb(wstrb), .MEM1_wdata(wdata),
        .MEM_uncache_rd_req(rd_req), .MEM_uncache_rd_type(rd_type), .MEM_uncache_rd_addr(rd_addr),
        .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .MEM_uncache_wr_req(wr_req), .MEM_uncache_wr_type(wr_type), .MEM_uncache_wr_addr(wr_addr),
        .MEM_uncache_wr_wstrb(wr_wstrb), .MEM_uncache_wr_data(wr_data),
        .wr_rdy(wr_rdy), .wr_ok(wr_ok),
        .uncache_Out(out), .MEM_unCache_data_ok(data_ok), .uncache_last_stall(last_stall)
    );

    typedef struct packed {
        logic        wr;
        logic [2:0]  typ;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } req_t;

    req_t        req_q[$];
    logic [31:0] done_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the number of cycles after the accept cycle until DONE is seen.
    int bad_ok;
    task automatic wait_done(input int max, output int cyc);
        cyc = 0;
        bad_ok = 0;
        do begin
            tick();
            cyc++;
            if (!last_stall && data_ok) bad_ok++;
        end while (!last_stall && cyc < max);
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [3:0] st, input logic [31:0] d, input logic [2:0] exp_typ);
        valid = 1'b1; dmwr = w; size = sz; paddr = a; wstrb = st; wdata = d;
        req_q.push_back('{wr: w, typ: exp_typ, addr: a, strb: w ? st : 4'h0, data: w ? d : 32'h0});
    endtask

    // Scoreboard monitor: new request pops the request queue, DONE pops the completion queue.
    logic prv_rd, prv_wr;
    req_t prv, cur, e;
    always @(negedge clk) begin
        if (!resetn) begin
            prv_rd = 1'b0; prv_wr = 1'b0; prv = '0;
        end else begin
            chk("req_exclusive", {31'b0, rd_req & wr_req}, 32'h0);
            cur = '{wr: wr_req, typ: wr_req ? wr_type : rd_type, addr: wr_req ? wr_addr : rd_addr,
                    strb: wr_req ? wr_wstrb : 4'h0, data: wr_req ? wr_data : 32'h0};
            if ((rd_req && !prv_rd) || (wr_req && !prv_wr)) begin
                chk("req_expected", {31'b0, req_q.size() != 0}, 32'h1);
                if (req_q.size() != 0) begin
                    e = req_q.pop_front();
                    chk("req_dir",  {31'b0, cur.wr}, {31'b0, e.wr});
                    chk("req_type", {29'b0, cur.typ}, {29'b0, e.typ});
                    chk("req_addr", cur.addr, e.addr);
                    chk("req_strb", {28'b0, cur.strb}, {28'b0, e.strb});
                    chk("req_data", cur.data, e.data);
                end
            end else if (rd_req || wr_req) begin
                chk("req_stable_addr", cur.addr, prv.addr);
                chk("req_stable_data", cur.data, prv.data);
            end
            if (last_stall) begin
                chk("done_expected", {31'b0, done_q.size() != 0}, 32'h1);
                if (done_q.size() != 0) chk("done_out", out, done_q.pop_front());
                chk("done_data_ok", {31'b0, data_ok}, 32'h1);
            end
            prv_rd = rd_req; prv_wr = wr_req; prv = cur;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int hold;
        resetn = 1'b0; valid = 1'b0; dmwr = 1'b0; size = 2'b00; paddr = '0; wstrb = '0; wdata = '0;
        rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0; wr_rdy = 1'b0; wr_ok = 1'b0;
        repeat (3) tick();
        chk("rst_rd_req", {31'b0, rd_req}, 32'h0);
        chk("rst_wr_req", {31'b0, wr_req}, 32'h0);
        chk("rst_data_ok", {31'b0, data_ok}, 32'h1);
        chk("rst_last_stall", {31'b0, last_stall}, 32'h0);
        chk("rst_out", out, 32'h0);
        chk("rst_rd_addr", rd_addr, 32'h0);
        resetn = 1'b1;
        tick();

        // Word load, bridge ready at once, data the cycle after rd_rdy.
        rd_rdy = 1'b1; ret_valid = 1'b1; ret_last = 1'b1; ret_data = 32'hDEADBEEF;
        issue(1'b0, 2'b10, 32'h1faf_f020, 4'h0, 32'h0, 3'b010);
        done_q.push_back(32'hDEADBEEF);
        tick();
        valid = 1'b0;
        chk("ld_req_latency", {31'b0, rd_req}, 32'h1);
        cyc = 1;
        wait_done(20, hold);
        cyc += hold;
        chk("ld_done_seen", {31'b0, last_stall}, 32'h1);
        chk("ld_latency", cyc, 32'd3);
        chk("ld_data_ok_busy", bad_ok, 32'd0);
        rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0;
        tick();
        chk("ld_stall_pulse", {31'b0, last_stall}, 32'h0);
        chk("ld_out_hold", out, 32'hDEADBEEF);

        // Byte store, wr_rdy after 4 cycles, wr_ok 2 cycles after that.
        issue(1'b1, 2'b00, 32'h1faf_f001, 4'b0010, 32'h0000_AB00, 3'b000);
        done_q.push_back(32'hDEADBEEF);
        tick();
        valid = 1'b0;
        hold = 0;
        for (int i = 0; i < 4; i++) begin
            hold += int'(wr_req);
            chk("st_busy", {31'b0, data_ok}, 32'h0);
            tick();
        end
        hold += int'(wr_req);
        wr_rdy = 1'b1;
        tick();
        wr_rdy = 1'b0;
        chk("st_req_hold", hold, 32'd5);
        chk("st_req_drop", {31'b0, wr_req}, 32'h0);
        chk("st_wait_busy", {31'b0, data_ok}, 32'h0);
        tick();
        chk("st_wait_busy2", {31'b0, data_ok}, 32'h0);
        wr_ok = 1'b1;
        tick();
        wr_ok = 1'b0;
        chk("st_done", {31'b0, last_stall}, 32'h1);
        chk("st_out_unchanged", out, 32'hDEADBEEF);
        tick();

        // Half load followed by a store accepted in DONE.
        rd_rdy = 1'b1; ret_valid = 1'b1; ret_last = 1'b1; ret_data = 32'h1234_5678;
        issue(1'b0, 2'b01, 32'h1faf_0004, 4'h0, 32'h0, 3'b001);
        done_q.push_back(32'h1234_5678);
        tick();
        valid = 1'b0;
        wait_done(20, hold);
        chk("b2b_ld_done", {31'b0, last_stall}, 32'h1);
        rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0;
        wr_rdy = 1'b1; wr_ok = 1'b1;
        issue(1'b1, 2'b11, 32'h1faf_0008, 4'b1111, 32'hCAFE_F00D, 3'b010);
        done_q.push_back(32'h1234_5678);
        tick();
        valid = 1'b0;
        chk("b2b_no_bubble", {31'b0, wr_req}, 32'h1);
        chk("b2b_busy", {31'b0, data_ok}, 32'h0);
        wait_done(20, hold);
        chk("b2b_st_done", {31'b0, last_stall}, 32'h1);
        chk("b2b_out_kept", out, 32'h1234_5678);
        wr_rdy = 1'b0; wr_ok = 1'b0;
        tick();

        // Valid pulsed during RD_WAIT, then a non-last beat before the real one.
        rd_rdy = 1'b1;
        issue(1'b0, 2'b10, 32'h1faf_0010, 4'h0, 32'h0, 3'b010);
        done_q.push_back(32'h0BAD_F00D);
        tick();
        valid = 1'b0;
        tick();
        rd_rdy = 1'b0;
        valid = 1'b1; dmwr = 1'b1; paddr = 32'h1faf_0020;
        tick();
        valid = 1'b0;
        chk("ign_rd_req", {31'b0, rd_req}, 32'h0);
        chk("ign_wr_req", {31'b0, wr_req}, 32'h0);
        ret_valid = 1'b1; ret_last = 1'b0; ret_data = 32'hBAD0_BAD0;
        tick();
        chk("nolast_wait", {31'b0, last_stall}, 32'h0);
        tick();
        chk("nolast_wait2", {31'b0, data_ok}, 32'h0);
        ret_last = 1'b1; ret_data = 32'h0BAD_F00D;
        tick();
        ret_valid = 1'b0; ret_last = 1'b0;
        chk("last_done", {31'b0, last_stall}, 32'h1);
        chk("last_out", out, 32'h0BAD_F00D);
        tick();

        // Reset while waiting for a write response.
        wr_rdy = 1'b1;
        issue(1'b1, 2'b10, 32'h1faf_0030, 4'b1111, 32'h5555_AAAA, 3'b010);
        tick();
        valid = 1'b0;
        tick();
        wr_rdy = 1'b0;
        chk("rstw_in_wait", {31'b0, data_ok}, 32'h0);
        resetn = 1'b0;
        #1;
        chk("rstw_wr_req", {31'b0, wr_req}, 32'h0);
        chk("rstw_data_ok", {31'b0, data_ok}, 32'h1);
        chk("rstw_out", out, 32'h0);
        chk("rstw_stall", {31'b0, last_stall}, 32'h0);
        tick();
        resetn = 1'b1;
        wr_ok = 1'b1;
        tick();
        wr_ok = 1'b0;
        chk("rstw_idle_after", {31'b0, last_stall}, 32'h0);
        tick();
        chk("sb_req_drained", req_q.size(), 32'd0);
        chk("sb_done_drained", done_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
